// File: rtl/br_rs_unit_pkg.sv
// Shared widths, opcode enum and uop/result structs for the branch reservation station.
package br_rs_unit_pkg;

    localparam int unsigned PRF_IDX_W = 6;
    localparam int unsigned ROB_IDX_W = 5;
    localparam int unsigned CDB_WIDTH = 4;

    typedef enum logic [2:0] {
        BR_JAL, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
    } br_op_e;

    typedef struct packed {
        logic [31:0]          pc;
        br_op_e               fu_opcode;
        logic [PRF_IDX_W-1:0] rd_phy;
        logic [PRF_IDX_W-1:0] rs1_phy;
        logic [PRF_IDX_W-1:0] rs2_phy;
        logic                 rs1_valid;
        logic                 rs2_valid;
        logic [31:0]          imm;
        logic [ROB_IDX_W-1:0] rob_id;
        logic [4:0]           rd_arch;
        logic                 predict_taken;
        logic [31:0]          predict_target;
    } br_uop_t;

    typedef struct packed {
        logic    valid;
        logic    rs1_rdy;
        logic    rs2_rdy;
        br_uop_t uop;
    } rs_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_id;
        logic [PRF_IDX_W-1:0] rd_phy;
        logic [4:0]           rd_arch;
        logic [31:0]          rd_value;
        logic [31:0]          pc;
        logic                 taken;
        logic                 miss;
        logic [31:0]          target;
    } br_res_t;

    function automatic logic tag_hit(
        input logic [CDB_WIDTH-1:0]                cdb_v,
        input logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] cdb_tag,
        input logic [PRF_IDX_W-1:0]                phy
    );
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < CDB_WIDTH; i++) begin
            if (cdb_v[i] && (cdb_tag[i] == phy)) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/br_rs_unit_alu.sv
// Combinational branch/jump resolve: taken, target, link value and mispredict flag.
module br_rs_unit_alu
    import br_rs_unit_pkg::*;
(
    input  br_op_e      op_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_target_i,
    output logic        taken_o,
    output logic [31:0] target_o,
    output logic [31:0] rd_value_o,
    output logic        miss_o
);

    logic [31:0] rel_tgt;
    logic [31:0] seq_pc;
    logic [31:0] jalr_tgt;
    logic        cond;

    always_comb begin
        rel_tgt  = pc_i + imm_i;
        seq_pc   = pc_i + 32'd4;
        jalr_tgt = (rs1_i + imm_i) & ~32'd1;
        cond     = 1'b0;
        unique case (op_i)
            BR_BEQ:  cond = (rs1_i == rs2_i);
            BR_BNE:  cond = (rs1_i != rs2_i);
            BR_BLT:  cond = ($signed(rs1_i) <  $signed(rs2_i));
            BR_BGE:  cond = ($signed(rs1_i) >= $signed(rs2_i));
            BR_BLTU: cond = (rs1_i <  rs2_i);
            BR_BGEU: cond = (rs1_i >= rs2_i);
            default: cond = 1'b1;
        endcase

        taken_o    = cond;
        target_o   = cond ? rel_tgt : seq_pc;
        rd_value_o = '0;
        miss_o     = (cond != pred_taken_i) || (cond && (rel_tgt != pred_target_i));
        // JAL is already redirected at decode, so it can never mispredict here.
        if (op_i == BR_JAL) begin
            taken_o    = 1'b1;
            target_o   = rel_tgt;
            rd_value_o = seq_pc;
            miss_o     = 1'b0;
        end else if (op_i == BR_JALR) begin
            taken_o    = 1'b1;
            target_o   = jalr_tgt;
            rd_value_o = seq_pc;
            miss_o     = (jalr_tgt != pred_target_i);
        end
    end

endmodule

// File: rtl/br_rs_unit.sv
// Branch reservation station (collapsing in-order queue) with a one-deep exec stage and registered result.
// Define BR_RS_DISPATCH_BYPASS_EN to capture same-cycle CDB wakeups on the dispatched uop.
module br_rs_unit
    import br_rs_unit_pkg::*;
#(
    parameter int unsigned BR_RS_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ds_valid,
    output logic                                ds_ready,
    input  br_uop_t                             ds_uop,
    output logic [PRF_IDX_W-1:0]                prf_rs1_phy,
    output logic [PRF_IDX_W-1:0]                prf_rs2_phy,
    input  logic [31:0]                         prf_rs1_value,
    input  logic [31:0]                         prf_rs2_value,
    input  logic [CDB_WIDTH-1:0]                cdb_valid,
    input  logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] cdb_rd_phy,
    output logic                                fu_cdb_valid,
    output logic [ROB_IDX_W-1:0]                fu_cdb_rob_id,
    output logic [PRF_IDX_W-1:0]                fu_cdb_rd_phy,
    output logic [4:0]                          fu_cdb_rd_arch,
    output logic [31:0]                         fu_cdb_rd_value,
    output logic                                br_valid,
    output logic [ROB_IDX_W-1:0]                br_rob_id,
    output logic [31:0]                         br_pc,
    output logic                                br_taken,
    output logic                                br_miss_predict,
    output logic [31:0]                         br_target_address
);

    localparam int unsigned CNT_W = $clog2(BR_RS_DEPTH + 1);

    rs_entry_t              ent_q [BR_RS_DEPTH];
    rs_entry_t              ent_d [BR_RS_DEPTH];
    rs_entry_t              woke  [BR_RS_DEPTH+1];
    rs_entry_t              new_ent;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       ins_pos;
    logic                   issue;
    logic [BR_RS_DEPTH-1:0] shift;
    br_uop_t                sel_uop;

    logic                   ex_valid_q;
    br_uop_t                ex_uop_q;
    logic [31:0]            ex_rs1_q;
    logic [31:0]            ex_rs2_q;
    br_res_t                res_q;

    logic                   alu_taken;
    logic [31:0]            alu_target;
    logic [31:0]            alu_rd_value;
    logic                   alu_miss;
    logic                   unused_ex;

    // Oldest-ready select; shift marks the selected slot and everything above it.
    always_comb begin
        cnt     = '0;
        issue   = 1'b0;
        shift   = '0;
        sel_uop = '0;
        for (int unsigned i = 0; i < BR_RS_DEPTH; i++) begin
            cnt = cnt + CNT_W'(ent_q[i].valid);
            if (!issue && ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                issue   = 1'b1;
                sel_uop = ent_q[i].uop;
            end
            shift[i] = issue;
        end
    end

    assign ds_ready    = (cnt != CNT_W'(BR_RS_DEPTH));
    assign ins_pos     = cnt - CNT_W'(issue);
    assign prf_rs1_phy = sel_uop.rs1_phy;
    assign prf_rs2_phy = sel_uop.rs2_phy;

    always_comb begin
        for (int unsigned i = 0; i < BR_RS_DEPTH; i++) begin
            woke[i]         = ent_q[i];
            woke[i].rs1_rdy = ent_q[i].rs1_rdy | tag_hit(cdb_valid, cdb_rd_phy, ent_q[i].uop.rs1_phy);
            woke[i].rs2_rdy = ent_q[i].rs2_rdy | tag_hit(cdb_valid, cdb_rd_phy, ent_q[i].uop.rs2_phy);
        end
        woke[BR_RS_DEPTH] = '0;
    end

    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.uop   = ds_uop;
`ifdef BR_RS_DISPATCH_BYPASS_EN
        new_ent.rs1_rdy = ds_uop.rs1_valid | tag_hit(cdb_valid, cdb_rd_phy, ds_uop.rs1_phy);
        new_ent.rs2_rdy = ds_uop.rs2_valid | tag_hit(cdb_valid, cdb_rd_phy, ds_uop.rs2_phy);
`else
        new_ent.rs1_rdy = ds_uop.rs1_valid;
        new_ent.rs2_rdy = ds_uop.rs2_valid;
`endif
        for (int unsigned i = 0; i < BR_RS_DEPTH; i++) begin
            ent_d[i] = shift[i] ? woke[i+1] : woke[i];
            if (ds_valid && ds_ready && (ins_pos == CNT_W'(i))) ent_d[i] = new_ent;
        end
    end

    br_rs_unit_alu u_alu (
        .op_i          (ex_uop_q.fu_opcode),
        .pc_i          (ex_uop_q.pc),
        .imm_i         (ex_uop_q.imm),
        .rs1_i         (ex_rs1_q),
        .rs2_i         (ex_rs2_q),
        .pred_taken_i  (ex_uop_q.predict_taken),
        .pred_target_i (ex_uop_q.predict_target),
        .taken_o       (alu_taken),
        .target_o      (alu_target),
        .rd_value_o    (alu_rd_value),
        .miss_o        (alu_miss)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BR_RS_DEPTH; i++) ent_q[i] <= '0;
            ex_valid_q <= 1'b0;
            ex_uop_q   <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            res_q      <= '0;
        end else begin
            for (int unsigned i = 0; i < BR_RS_DEPTH; i++) ent_q[i] <= ent_d[i];
            ex_valid_q  <= issue;
            if (issue) begin
                ex_uop_q <= sel_uop;
                ex_rs1_q <= prf_rs1_value;
                ex_rs2_q <= prf_rs2_value;
            end
            res_q.valid <= ex_valid_q;
            if (ex_valid_q) begin
                res_q.rob_id   <= ex_uop_q.rob_id;
                res_q.rd_phy   <= ex_uop_q.rd_phy;
                res_q.rd_arch  <= ex_uop_q.rd_arch;
                res_q.rd_value <= alu_rd_value;
                res_q.pc       <= ex_uop_q.pc;
                res_q.taken    <= alu_taken;
                res_q.miss     <= alu_miss;
                res_q.target   <= alu_target;
            end
        end
    end

    assign unused_ex = ^{ex_uop_q.rs1_phy, ex_uop_q.rs2_phy, ex_uop_q.rs1_valid, ex_uop_q.rs2_valid};

    assign fu_cdb_valid      = res_q.valid;
    assign fu_cdb_rob_id     = res_q.rob_id;
    assign fu_cdb_rd_phy     = res_q.rd_phy;
    assign fu_cdb_rd_arch    = res_q.rd_arch;
    assign fu_cdb_rd_value   = res_q.rd_value;
    assign br_valid          = res_q.valid;
    assign br_rob_id         = res_q.rob_id;
    assign br_pc             = res_q.pc;
    assign br_taken          = res_q.taken;
    assign br_miss_predict   = res_q.miss;
    assign br_target_address = res_q.target;

endmodule

// File: tb/tb_br_rs_unit.sv
// Randomised bench for br_rs_unit against a queue-based reference model, plus directed cases.
module tb_br_rs_unit;
    import br_rs_unit_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                                clk = 1'b0;
    logic                                rst;
    logic                                ds_valid;
    logic                                ds_ready;
    br_uop_t                             ds_uop;
    logic [PRF_IDX_W-1:0]                prf_rs1_phy, prf_rs2_phy;
    logic [31:0]                         prf_rs1_value, prf_rs2_value;
    logic [CDB_WIDTH-1:0]                cdb_valid;
    logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] cdb_rd_phy;
    logic                                fu_cdb_valid;
    logic [ROB_IDX_W-1:0]                fu_cdb_rob_id;
    logic [PRF_IDX_W-1:0]                fu_cdb_rd_phy;
    logic [4:0]                          fu_cdb_rd_arch;
    logic [31:0]                         fu_cdb_rd_value;
    logic                                br_valid;
    logic [ROB_IDX_W-1:0]                br_rob_id;
    logic [31:0]                         br_pc;
    logic                                br_taken;
    logic                                br_miss_predict;
    logic [31:0]                         br_target_address;

    logic [31:0] prf_mem [64];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign prf_rs1_value = prf_mem[prf_rs1_phy];
    assign prf_rs2_value = prf_mem[prf_rs2_phy];

    br_rs_unit #(.BR_RS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ds_valid(ds_valid), .ds_ready(ds_ready), .ds_uop(ds_uop),
        .prf_rs1_phy(prf_rs1_phy), .prf_rs2_phy(prf_rs2_phy),
        .prf_rs1_value(prf_rs1_value), .prf_rs2_value(prf_rs2_value),
        .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy),
        .fu_cdb_valid(fu_cdb_valid), .fu_cdb_rob_id(fu_cdb_rob_id), .fu_cdb_rd_phy(fu_cdb_rd_phy),
        .fu_cdb_rd_arch(fu_cdb_rd_arch), .fu_cdb_rd_value(fu_cdb_rd_value),
        .br_valid(br_valid), .br_rob_id(br_rob_id), .br_pc(br_pc), .br_taken(br_taken),
        .br_miss_predict(br_miss_predict), .br_target_address(br_target_address)
    );

    // Reference model: arrival-ordered list of waiting uops and a two-stage result pipe.
    typedef struct { br_uop_t u; bit r1; bit r2; } m_ent_t;
    m_ent_t  mq[$];
    br_res_t m_ex, m_out;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic br_res_t resolve(input br_uop_t u);
        br_res_t r;
        logic [31:0] a, b;
        bit c;
        a = prf_mem[u.rs1_phy];
        b = prf_mem[u.rs2_phy];
        r = '0;
        r.valid = 1'b1; r.rob_id = u.rob_id; r.rd_phy = u.rd_phy; r.rd_arch = u.rd_arch; r.pc = u.pc;
        case (u.fu_opcode)
            BR_JAL:  begin r.taken = 1; r.target = u.pc + u.imm; r.rd_value = u.pc + 4; r.miss = 0; end
            BR_JALR: begin
                r.taken = 1; r.target = (a + u.imm) & 32'hffff_fffe; r.rd_value = u.pc + 4;
                r.miss = (r.target != u.predict_target);
            end
            default: begin
                case (u.fu_opcode)
                    BR_BEQ:  c = (a == b);
                    BR_BNE:  c = (a != b);
                    BR_BLT:  c = ($signed(a) < $signed(b));
                    BR_BGE:  c = !($signed(a) < $signed(b));
                    BR_BLTU: c = (a < b);
                    default: c = !(a < b);
                endcase
                r.taken = c; r.rd_value = 0;
                r.target = c ? u.pc + u.imm : u.pc + 4;
                r.miss = (c != u.predict_taken) || (c && r.target != u.predict_target);
            end
        endcase
        return r;
    endfunction

    function automatic int m_sel();
        for (int i = 0; i < mq.size(); i++) if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    function automatic bit cdb_hit(input logic [PRF_IDX_W-1:0] phy);
        for (int j = 0; j < CDB_WIDTH; j++) if (cdb_valid[j] && cdb_rd_phy[j] == phy) return 1;
        return 0;
    endfunction

    task automatic check_now();
        int k;
        logic [PRF_IDX_W-1:0] e1, e2;
        k = m_sel();
        e1 = (k >= 0) ? mq[k].u.rs1_phy : '0;
        e2 = (k >= 0) ? mq[k].u.rs2_phy : '0;
        chk("ds_ready", ds_ready, mq.size() < DEPTH);
        chk("prf_phy", {prf_rs1_phy, prf_rs2_phy}, {e1, e2});
        chk("valid", {fu_cdb_valid, br_valid}, {m_out.valid, m_out.valid});
        if (m_out.valid) begin
            chk("fu_cdb", {fu_cdb_rob_id, fu_cdb_rd_phy, fu_cdb_rd_arch, fu_cdb_rd_value},
                {m_out.rob_id, m_out.rd_phy, m_out.rd_arch, m_out.rd_value});
            chk("br", {br_rob_id, br_pc, br_taken, br_miss_predict, br_target_address},
                {m_out.rob_id, m_out.pc, m_out.taken, m_out.miss, m_out.target});
        end
    endtask

    task automatic model_edge();
        int k;
        bit room;
        m_ent_t e;
        room  = mq.size() < DEPTH;
        k     = m_sel();
        m_out = m_ex;
        m_ex  = '0;
        if (k >= 0) begin
            m_ex = resolve(mq[k].u);
            mq.delete(k);
        end
        foreach (mq[i]) begin
            if (cdb_hit(mq[i].u.rs1_phy)) mq[i].r1 = 1;
            if (cdb_hit(mq[i].u.rs2_phy)) mq[i].r2 = 1;
        end
        if (ds_valid && room) begin
            e.u = ds_uop; e.r1 = ds_uop.rs1_valid; e.r2 = ds_uop.rs2_valid;
`ifdef BR_RS_DISPATCH_BYPASS_EN
            e.r1 = e.r1 | cdb_hit(ds_uop.rs1_phy);
            e.r2 = e.r2 | cdb_hit(ds_uop.rs2_phy);
`endif
            mq.push_back(e);
        end
    endtask

    task automatic cycle(input logic dv, input br_uop_t u, input logic [CDB_WIDTH-1:0] cv,
                         input logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] cp);
        ds_valid = dv; ds_uop = u; cdb_valid = cv; cdb_rd_phy = cp;
        @(negedge clk);
        check_now();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1; ds_valid = 1'b0; cdb_valid = '0; cdb_rd_phy = '0; ds_uop = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); m_ex = '0; m_out = '0;
    endtask

    function automatic br_uop_t mk(input br_op_e op, input logic [31:0] pc, input logic [31:0] imm,
                                   input int rd, input int s1, input int s2, input bit v1, input bit v2,
                                   input int rob, input bit pt, input logic [31:0] ptgt);
        br_uop_t u;
        u.pc = pc; u.fu_opcode = op; u.imm = imm;
        u.rd_phy = PRF_IDX_W'(rd); u.rs1_phy = PRF_IDX_W'(s1); u.rs2_phy = PRF_IDX_W'(s2);
        u.rs1_valid = v1; u.rs2_valid = v2;
        u.rob_id = ROB_IDX_W'(rob); u.rd_arch = 5'(rob + 3);
        u.predict_taken = pt; u.predict_target = ptgt;
        return u;
    endfunction

    task automatic run1(input br_uop_t u);
        cycle(1'b1, u, '0, '0);
        idle();
        idle();
    endtask

    function automatic br_uop_t rnd_uop();
        br_uop_t u;
        u.pc        = $urandom & 32'hffff_fffc;
        u.fu_opcode = br_op_e'(3'($urandom_range(0, 7)));
        u.imm       = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
        u.rd_phy    = PRF_IDX_W'($urandom_range(0, 63));
        u.rs1_phy   = PRF_IDX_W'($urandom_range(0, 15));
        u.rs2_phy   = PRF_IDX_W'($urandom_range(0, 15));
        u.rs1_valid = 1'($urandom_range(0, 1));
        u.rs2_valid = 1'($urandom_range(0, 1));
        u.rob_id    = ROB_IDX_W'($urandom_range(0, 31));
        u.rd_arch   = 5'($urandom_range(0, 31));
        u.predict_taken  = 1'($urandom_range(0, 1));
        u.predict_target = $urandom_range(0, 1) ? u.pc + u.imm : $urandom;
        return u;
    endfunction

    task automatic rnd_cycles(input int n);
        logic [CDB_WIDTH-1:0]                cv;
        logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] cp;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < CDB_WIDTH; j++) begin
                cv[j] = ($urandom_range(0, 9) < 3);
                cp[j] = PRF_IDX_W'($urandom_range(0, 15));
            end
            cycle(($urandom_range(0, 9) < 6), rnd_uop(), cv, cp);
        end
    endtask

    initial begin
        logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] cp;
        for (int i = 0; i < 64; i++) begin
            case (i % 4)
                0: prf_mem[i] = $urandom;
                1: prf_mem[i] = 32'($urandom_range(0, 3));
                2: prf_mem[i] = 32'hffff_ffff - 32'($urandom_range(0, 3));
                default: prf_mem[i] = 32'h8000_0000 + 32'($urandom_range(0, 3));
            endcase
        end
        prf_mem[0] = 0; prf_mem[7] = 0; prf_mem[20] = 32'h100;
        prf_mem[21] = 5; prf_mem[22] = 5; prf_mem[23] = 32'hffff_ffff; prf_mem[24] = 1;

        do_reset();
        chk("rst_ready", ds_ready, 1'b1);
        chk("rst_out", {fu_cdb_valid, br_valid, fu_cdb_rob_id, fu_cdb_rd_phy, fu_cdb_rd_arch, fu_cdb_rd_value,
                        br_rob_id, br_pc, br_taken, br_miss_predict, br_target_address,
                        prf_rs1_phy, prf_rs2_phy}, 128'd0);

        run1(mk(BR_JAL, 32'h0, 32'hffff, 1, 0, 0, 1, 1, 1, 1, 32'h4));
        chk("jal_valid", {fu_cdb_valid, br_valid}, 2'b11);
        chk("jal_rd", {fu_cdb_rd_phy, fu_cdb_rd_value}, {6'd1, 32'h4});
        chk("jal_br", {br_target_address, br_miss_predict}, {32'hffff, 1'b0});

        run1(mk(BR_BEQ, 32'h0, 32'hffff, 2, 0, 0, 1, 1, 2, 0, 32'h0));
        chk("beq", {br_taken, br_miss_predict, br_target_address, fu_cdb_rd_value}, {2'b11, 32'hffff, 32'h0});

        run1(mk(BR_BNE, 32'h40, 32'h80, 3, 21, 22, 1, 1, 3, 0, 32'h0));
        chk("bne", {br_taken, br_miss_predict, br_target_address}, {2'b00, 32'h44});

        run1(mk(BR_BLT, 32'h40, 32'h80, 4, 23, 24, 1, 1, 4, 1, 32'hc0));
        chk("blt", {br_taken, br_miss_predict, br_target_address}, {2'b10, 32'hc0});

        run1(mk(BR_BLTU, 32'h40, 32'h80, 5, 23, 24, 1, 1, 5, 0, 32'h0));
        chk("bltu", {br_taken, br_miss_predict, br_target_address}, {2'b00, 32'h44});

        run1(mk(BR_JALR, 32'h200, 32'h3, 6, 20, 0, 1, 1, 6, 1, 32'h102));
        chk("jalr", {br_target_address, br_miss_predict, fu_cdb_rd_value}, {32'h102, 1'b0, 32'h204});

        cycle(1'b1, mk(BR_BEQ, 32'h300, 32'h10, 8, 7, 0, 0, 1, 7, 1, 32'h310), '0, '0);
        idle(); idle(); idle();
        chk("dep_wait", {fu_cdb_valid, prf_rs1_phy}, {1'b0, 6'd0});
        cp = '0; cp[2] = 6'd7;
        cycle(1'b0, '0, 4'b0100, cp);
        chk("dep_sel", prf_rs1_phy, 6'd7);
        idle(); idle();
        chk("dep_out", {fu_cdb_valid, br_rob_id, br_taken}, {1'b1, 5'd7, 1'b1});

        for (int i = 0; i < 4; i++)
            cycle(1'b1, mk(BR_BNE, 32'h400 + 32'(i * 4), 32'h8, 10 + i, 10 + i, 0, 0, 1, 10 + i, 0, 0), '0, '0);
        chk("full_ready", ds_ready, 1'b0);
        cycle(1'b1, mk(BR_JAL, 32'h500, 32'h8, 30, 0, 0, 1, 1, 30, 0, 0), '0, '0);
        cp = '0; cp[0] = 6'd12; cp[1] = 6'd10;
        cycle(1'b0, '0, 4'b0011, cp);
        chk("wake_first", prf_rs1_phy, 6'd10);
        chk("full_issue_ready", ds_ready, 1'b0);
        idle();
        chk("wake_second", prf_rs1_phy, 6'd12);
        cp = '0; cp[3] = 6'd11; cp[1] = 6'd13;
        cycle(1'b0, '0, 4'b1010, cp);
        for (int i = 0; i < 6; i++) idle();

        rnd_cycles(1500);
        do_reset();
        chk("midrst", {ds_ready, fu_cdb_valid, br_valid, prf_rs1_phy, prf_rs2_phy}, {3'b100, 12'd0});
        rnd_cycles(1500);
        for (int i = 0; i < 40; i++) rnd_cycles(0);
        cp = '1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < CDB_WIDTH; j++) cp[j] = PRF_IDX_W'((i * CDB_WIDTH + j) % 16);
            cycle(1'b0, '0, '1, cp);
        end
        for (int i = 0; i < 8; i++) idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/br_rs_unit.md
Name:
br_rs_unit

Overview:
- Branch reservation station with an integrated branch execution unit in the out-of-order backend.
- Accepts branch/jump uops from dispatch and holds them until both source physical registers are ready. Readiness comes from dispatch or from CDB wakeup.
- Issues the oldest ready uop, reads operands from the PRF, and resolves it.
- Broadcasts the link value on its own CDB port and the resolution on a dedicated branch-CDB port toward the ROB and front end.

Parameters:
- BR_RS_DEPTH, 4, number of entries.
- PRF_IDX_W, 6, physical register index width.
- ROB_IDX_W, 5, ROB id width.
- CDB_WIDTH, 4, number of CDB wakeup ports.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ds_valid  in  1  dispatch uop valid.
- ds_ready  out  1  RS can accept a uop this cycle.
- ds_uop  in  struct  pc[32], fu_opcode, rd_phy, rs1_phy, rs2_phy, rs1_valid, rs2_valid, imm[32], rob_id, rd_arch[5], predict_taken, predict_target[32].
- prf_rs1_phy, prf_rs2_phy  out  PRF_IDX_W  PRF read addresses.
- prf_rs1_value, prf_rs2_value  in  32  PRF read data, combinational.
- cdb_valid[CDB_WIDTH]  in  1  wakeup broadcast valid.
- cdb_rd_phy[CDB_WIDTH]  in  PRF_IDX_W  wakeup tags; includes this unit's own port.
- fu_cdb_valid, fu_cdb_rob_id, fu_cdb_rd_phy, fu_cdb_rd_arch, fu_cdb_rd_value  out  result broadcast.
- br_valid, br_rob_id, br_pc[32], br_taken, br_miss_predict, br_target_address[32]  out  branch resolution.

Behaviour:
- Reset: all entries invalid; exec register invalid; fu_cdb_valid=0 and br_valid=0; other outputs 0.

Entries and dispatch
- Each entry stores the uop plus rs1_rdy and rs2_rdy.
- ds_ready = !full; it is computed from registered state only. A slot freed in the same cycle does not count.
- On ds_valid&&ds_ready, the uop is written at the clock edge with rdy=rs*_valid.
- Entries are kept in arrival order as a collapsing queue.

Wakeup
- Each cycle, any valid entry whose rsX_phy equals a valid cdb_rd_phy[i] sets rsX_rdy at the edge.
- Wakeup does not apply to a uop being written in the same cycle (but see the optional feature).

Select and issue
- Each cycle, the lowest-index entry with both rdy bits set is selected.
- The selected entry drives prf_rs*_phy; when nothing is selected these are 0.
- At the edge, the uop and PRF values are latched into the exec register and the entry is freed; the queue collapses.
- Throughput is at most one issue per cycle.

Execute (combinational from the exec register)
- BEQ/BNE/BLT/BGE use signed compares; BLTU/BGEU use unsigned compares.
- Branch taken: target=pc+imm. Branch not taken: target=pc+4.
- Branch miss_predict = (taken != predict_taken) || (taken && target != predict_target).
- Branch rd_value = 0.
- JAL: taken=1, target=pc+imm, rd_value=pc+4. miss_predict=0 always, because the front end redirects JAL at decode.
- JALR: taken=1, target=(rs1+imm)&~1, rd_value=pc+4, miss_predict=(target != predict_target).
- All arithmetic is 32-bit with wrap-around.

Outputs
- Results are registered at the next edge. fu_cdb and br outputs are valid for exactly one cycle, simultaneously, for every issued uop.
- Latency: a uop dispatched ready at edge T appears on the outputs after edge T+2.
- There is no backpressure from either CDB port.

Boundaries
- Full with a simultaneous issue: ds_ready stays 0 in that cycle.
- Empty: nothing issues.
- rst asserted mid-operation clears all state at the next edge.

Optional Feature:
- Macro BR_RS_DISPATCH_BYPASS_EN.
- When defined: a uop dispatched in the same cycle as a matching cdb broadcast is written with the corresponding rdy bit set.
- When undefined: that wakeup is missed. Dispatch must then sample PRF valid bits that already include same-cycle writes.

Decomposition:
- cpu_params package: CDB_WIDTH, PRF_IDX_W, ROB_IDX_W.
- uop_types package: uop struct and fu_opcode enum (BR_JAL, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU).
- One natural sub-module: br_alu, the pure combinational resolve logic (taken, target, rd_value, miss_predict).

Test Plan:
- JAL, pc=0, imm=0xffff, rd_phy=1, sources ready, predict_target=4 → after 3 edges: fu_cdb_valid=1, rd_value=4, rd_phy=1; br_target_address=0xffff, br_miss_predict=0.
- BEQ x0,x0, imm=0xffff, predict_taken=0 → br_taken=1, br_miss_predict=1, target=0xffff.
- BNE rs1=5, rs2=5, predict_taken=0 → taken=0, target=pc+4, miss_predict=0. BLT -1<1 → taken=1; BLTU 0xffffffff<1 → taken=0.
- Dependency: uop with rs1_valid=0, rs1_phy=7 → no issue; cdb_valid with rd_phy=7 → issues next cycle, result two edges later.
- Fill 4 entries not ready → ds_ready=0. Wake entries 2 and 0 together → entry 0 issues first and entry 2 issues the following cycle.
- JALR rs1=0x100, imm=3, predict_target=0x102 → target=0x102, miss_predict=0, rd_value=pc+4.
